fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the CPU control/decode logic.
- Owns the PC register and issues one-outstanding-request fetches to instruction memory over a req/rvalid handshake.
- Holds the fetched instruction stable and presents its op/funct3/funct7b5 fields to the controller.
- Consumes the controller's PCSrc decision and the datapath's target address to select the next PC, and counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction driven on instr when no valid instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  downstream hold; keeps the current instruction presented.
- PCSrc  input  1  from controller; 1 = take PCTarget at retirement.
- PCTarget  input  32  branch/jump/jalr target from datapath.
- imem_req  output  1  single-cycle fetch request pulse.
- imem_addr  output  32  fetch address; equals pc while imem_req=1.
- imem_rvalid  input  1  read data valid from instruction memory.
- imem_rdata  input  32  instruction word.
- instr_valid  output  1  instr/pc hold a real instruction.
- instr  output  32  held instruction, or NOP_INSTR when instr_valid=0.
- op  output  7  instr[6:0].
- funct3  output  3  instr[14:12].
- funct7b5  output  1  instr[30].
- pc  output  32  address of the held/being-fetched instruction.
- pc_plus4  output  32  pc + 4, modulo 2^32.
- misalign_fault  output  1  sticky; set on a misaligned redirect target.
- instret  output  32  retired-instruction counter.

Behaviour:
- Reset (sync, highest priority, overrides any state):
  - pc=RESET_PC, state=IDLE.
  - instr register=NOP_INSTR, instr_valid=0, imem_req=0, misalign_fault=0, instret=0.
- FSM states: IDLE, REQ, WAIT, VALID, FAULT.
  - IDLE: outputs quiet; next cycle goes to REQ. Exactly one cycle, entered only from reset.
  - REQ: imem_req=1, imem_addr=pc, for exactly one cycle; then WAIT. imem_rvalid in REQ is ignored.
  - WAIT: imem_req=0. On imem_rvalid=1, capture imem_rdata into the instr register, set instr_valid=1, go to VALID. Otherwise remain in WAIT with no timeout.
  - VALID: instr, pc and decoded fields are held stable.
    - stall=1: remain in VALID, nothing changes.
    - stall=0: the instruction retires this cycle. instret increments, wrapping 0xFFFF_FFFF to 0.
      - PCSrc=0: pc <= pc_plus4.
      - PCSrc=1 and PCTarget[1:0]==0: pc <= PCTarget.
      - After either of the above: instr_valid <= 0, instr <= NOP_INSTR, go to REQ.
      - PCSrc=1 and PCTarget[1:0]!=0: misalign_fault <= 1, instr_valid <= 0, instr <= NOP_INSTR, pc unchanged, go to FAULT. instret still increments.
  - FAULT: terminal until reset. imem_req=0, instr_valid=0, imem_rvalid ignored.
- Decoded fields are always slices of the instr output. When not valid, the controller sees a NOP: no MemWrite, no Branch, no Jump.
- Throughput: at most one instruction per 3 cycles (REQ, WAIT with rvalid, VALID with stall=0). Each extra WAIT cycle or stall cycle adds 1.
- Wrap-around: pc_plus4 at 0xFFFF_FFFC is 0x0000_0000; no fault.
- Memory contract: at most one outstanding request. Instruction memory discards any in-flight response when reset is asserted. A reset asserted during WAIT therefore needs no drain.
- Simultaneous stall=1 and PCSrc=1 in VALID: stall wins, and the redirect is evaluated again on the first cycle with stall=0.

Test Plan:
- Reset then sequential fetch, rvalid 1 cycle after req, stall=0, PCSrc=0 -> imem_addr pulses 0x0, 0x4, 0x8 exactly 3 cycles apart; instret reaches 3 after the third retirement; op matches rdata[6:0].
- Memory latency of 4 WAIT cycles on rdata=0x00C58063 (beq) -> instr_valid asserts only on the cycle after rvalid; op=7'b1100011, funct3=000; no second imem_req while waiting.
- Redirect from VALID with PCSrc=1, PCTarget=0x0000_0100 -> next imem_addr=0x100; instr shows NOP_INSTR during REQ/WAIT; instret+1.
- stall=1 held 5 cycles with PCSrc=1 and a changing PCTarget, then stall=0 with PCTarget=0x40 -> pc/instr constant during the stall; next fetch at 0x40; instret increments once.
- PCTarget=0x102 with PCSrc=1 -> misalign_fault=1 and sticky; no further imem_req; pc unchanged; sync reset clears it and fetch restarts at RESET_PC.
- RESET_PC=0xFFFF_FFFC -> pc_plus4=0x0; the second fetch address is 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing single-outstanding instruction fetches and presenting the held instruction
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_fault,
  output logic [31:0] instret
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, VALID, FAULT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, instret_q, instret_d;
  logic        valid_q, valid_d, fault_q, fault_d;
  logic        retire, bad_target, capture;
  assign retire     = state_q == VALID && !stall;
  assign bad_target = retire && PCSrc && PCTarget[1:0] != 2'b00;
  assign capture    = state_q == WAIT && imem_rvalid;
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE  ? REQ :
              state_q == REQ   ? WAIT :
              state_q == WAIT  ? (imem_rvalid ? VALID : WAIT) :
              state_q == VALID ? (stall ? VALID : bad_target ? FAULT : REQ) :
              FAULT;
  end
  // A misaligned redirect still retires the instruction but leaves pc at the faulting instruction.
  always_comb begin
    pc_d      = retire && !bad_target ? (PCSrc ? PCTarget : pc_plus4) : pc_q;
    instr_d   = capture ? imem_rdata : retire ? NOP_INSTR : instr_q;
    valid_d   = capture ? 1'b1 : retire ? 1'b0 : valid_q;
    fault_d   = fault_q | bad_target;
    instret_d = instret_q + {31'b0, retire};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      instret_q <= 32'b0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
      instret_q <= instret_d;
    end
  end
  always_comb begin
    imem_req       = state_q == REQ;
    imem_addr      = pc_q;
    instr_valid    = valid_q;
    instr          = instr_q;
    op             = instr_q[6:0];
    funct3         = instr_q[14:12];
    funct7b5       = instr_q[30];
    pc             = pc_q;
    pc_plus4       = pc_q + 32'd4;
    misalign_fault = fault_q;
    instret        = instret_q;
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, directed corner sequences and randomized transactions against a fetch model
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, PCSrc = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] PCTarget = 32'h0, imem_rdata = 32'h0;
  logic        req, valid, f7, fault;
  logic [31:0] addr, instr, pc, pcp4, instret;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic        d2_req, d2_valid, d2_f7, d2_fault;
  logic [31:0] d2_addr, d2_instr, d2_pc, d2_pcp4, d2_instret;
  logic [6:0]  d2_op;
  logic [2:0]  d2_f3;
  int total = 0, bad = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .imem_req(req), .imem_addr(addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(valid), .instr(instr), .op(op), .funct3(f3), .funct7b5(f7),
    .pc(pc), .pc_plus4(pcp4), .misalign_fault(fault), .instret(instret)
  );
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .imem_req(d2_req), .imem_addr(d2_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(d2_valid), .instr(d2_instr), .op(d2_op), .funct3(d2_f3), .funct7b5(d2_f7),
    .pc(d2_pc), .pc_plus4(d2_pcp4), .misalign_fault(d2_fault), .instret(d2_instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic chk_fields(input string n, input logic [31:0] e);
    logic [31:0] w;
    w = e;
    chk({n, "_instr"}, instr, w);
    chk({n, "_op"}, {25'b0, op}, {25'b0, w[6:0]});
    chk({n, "_f3"}, {29'b0, f3}, {29'b0, w[14:12]});
    chk({n, "_f7b5"}, {31'b0, f7}, {31'b0, w[30]});
  endtask

  typedef struct {
    logic st, src, rv;
    logic [31:0] tgt, rd;
    logic req, v;
    logic [31:0] addr, ins, pc, cnt;
  } vec_t;
  vec_t tv[$];

  logic [31:0] mpc, mcnt, data, tgt;
  logic        src, mis;
  int          lat, ns;

  initial begin
    tv.push_back('{1'b0,1'b0,1'b0,32'h0,32'h0,         1'b1,1'b0,32'h0,  NOP,         32'h0,  32'd0});
    tv.push_back('{1'b0,1'b0,1'b1,32'h0,32'hDEADBEEF,  1'b0,1'b0,32'h0,  NOP,         32'h0,  32'd0});
    tv.push_back('{1'b0,1'b0,1'b1,32'h0,32'h00500093,  1'b0,1'b1,32'h0,  32'h00500093,32'h0,  32'd0});
    tv.push_back('{1'b0,1'b0,1'b0,32'h0,32'h0,         1'b1,1'b0,32'h4,  NOP,         32'h4,  32'd1});
    tv.push_back('{1'b0,1'b0,1'b0,32'h0,32'h0,         1'b0,1'b0,32'h4,  NOP,         32'h4,  32'd1});
    tv.push_back('{1'b0,1'b0,1'b1,32'h0,32'h40A00113,  1'b0,1'b1,32'h4,  32'h40A00113,32'h4,  32'd1});
    tv.push_back('{1'b0,1'b0,1'b0,32'h0,32'h0,         1'b1,1'b0,32'h8,  NOP,         32'h8,  32'd2});
    tv.push_back('{1'b0,1'b0,1'b0,32'h0,32'h0,         1'b0,1'b0,32'h8,  NOP,         32'h8,  32'd2});
    tv.push_back('{1'b0,1'b0,1'b1,32'h0,32'h002081B3,  1'b0,1'b1,32'h8,  32'h002081B3,32'h8,  32'd2});
    tv.push_back('{1'b0,1'b1,1'b0,32'h100,32'h0,       1'b1,1'b0,32'h100,NOP,         32'h100,32'd3});
    tv.push_back('{1'b0,1'b0,1'b0,32'h0,32'h0,         1'b0,1'b0,32'h100,NOP,         32'h100,32'd3});
    tv.push_back('{1'b0,1'b0,1'b1,32'h0,32'h0000A183,  1'b0,1'b1,32'h100,32'h0000A183,32'h100,32'd3});
    tv.push_back('{1'b1,1'b1,1'b0,32'h200,32'h0,       1'b0,1'b1,32'h100,32'h0000A183,32'h100,32'd3});
    tv.push_back('{1'b1,1'b1,1'b0,32'h304,32'h0,       1'b0,1'b1,32'h100,32'h0000A183,32'h100,32'd3});
    tv.push_back('{1'b1,1'b1,1'b0,32'h7,32'h0,         1'b0,1'b1,32'h100,32'h0000A183,32'h100,32'd3});
    tv.push_back('{1'b1,1'b1,1'b0,32'h102,32'h0,       1'b0,1'b1,32'h100,32'h0000A183,32'h100,32'd3});
    tv.push_back('{1'b1,1'b1,1'b0,32'h88,32'h0,        1'b0,1'b1,32'h100,32'h0000A183,32'h100,32'd3});
    tv.push_back('{1'b0,1'b1,1'b0,32'h40,32'h0,        1'b1,1'b0,32'h40, NOP,         32'h40, 32'd4});

    cyc; cyc;
    reset = 1'b0;
    chk("rst_req", {31'b0, req}, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instret", instret, 32'h0);
    chk_fields("rst", NOP);
    chk("wrap_pc", d2_pc, 32'hFFFF_FFFC);
    chk("wrap_pcp4", d2_pcp4, 32'h0);

    for (int i = 0; i < tv.size(); i++) begin
      stall = tv[i].st; PCSrc = tv[i].src; imem_rvalid = tv[i].rv;
      PCTarget = tv[i].tgt; imem_rdata = tv[i].rd;
      cyc;
      chk($sformatf("vec%0d_req", i), {31'b0, req}, {31'b0, tv[i].req});
      if (tv[i].req) chk($sformatf("vec%0d_addr", i), addr, tv[i].addr);
      chk($sformatf("vec%0d_valid", i), {31'b0, valid}, {31'b0, tv[i].v});
      chk($sformatf("vec%0d_pc", i), pc, tv[i].pc);
      chk($sformatf("vec%0d_instret", i), instret, tv[i].cnt);
      chk_fields($sformatf("vec%0d", i), tv[i].ins);
      if (i == 3) chk("wrap_second_addr", {d2_addr[31:1], d2_req}, 32'h1);
    end

    // four quiet WAIT cycles, then a beq arrives
    stall = 1'b0; PCSrc = 1'b0; imem_rvalid = 1'b0;
    cyc;
    for (int k = 0; k < 4; k++) begin
      chk("lat_quiet", {30'b0, req, valid}, 32'h0);
      if (k < 3) cyc;
    end
    imem_rvalid = 1'b1; imem_rdata = 32'h00C58063;
    cyc;
    imem_rvalid = 1'b0;
    chk("lat_valid", {31'b0, valid}, 32'h1);
    chk("lat_op", {25'b0, op}, 32'h63);
    chk("lat_f3", {29'b0, f3}, 32'h0);
    chk_fields("lat", 32'h00C58063);

    PCSrc = 1'b1; PCTarget = 32'h102;
    cyc;
    PCSrc = 1'b0;
    chk("mis_fault", {31'b0, fault}, 32'h1);
    chk("mis_valid", {31'b0, valid}, 32'h0);
    chk("mis_pc", pc, 32'h40);
    chk("mis_instret", instret, 32'd5);
    chk_fields("mis", NOP);
    for (int k = 0; k < 6; k++) begin
      imem_rvalid = k[0];
      cyc;
      chk("mis_sticky", {29'b0, req, valid, fault}, 32'h1);
    end
    imem_rvalid = 1'b0; reset = 1'b1;
    cyc;
    reset = 1'b0;
    chk("mis_rst_fault", {31'b0, fault}, 32'h0);
    chk("mis_rst_pc", pc, 32'h0);
    chk("mis_rst_instret", instret, 32'h0);
    cyc;
    chk("mis_restart", {addr[31:1], req}, 32'h1);

    mpc = 32'h0; mcnt = 32'h0;
    for (int t = 0; t < 60; t++) begin
      chk("rnd_req", {31'b0, req}, 32'h1);
      chk("rnd_addr", addr, mpc);
      chk("rnd_instret", instret, mcnt);
      chk_fields("rnd_idle", NOP);
      lat = $urandom_range(0, 3);
      imem_rvalid = $urandom_range(0, 1) == 1;
      cyc;
      imem_rvalid = 1'b0;
      repeat (lat) begin
        cyc;
        chk("rnd_wait", {30'b0, req, valid}, 32'h0);
      end
      data = $urandom;
      imem_rvalid = 1'b1; imem_rdata = data;
      cyc;
      imem_rvalid = 1'b0; imem_rdata = $urandom;
      chk("rnd_valid", {31'b0, valid}, 32'h1);
      chk("rnd_pc", pc, mpc);
      chk_fields("rnd", data);
      ns = $urandom_range(0, 3);
      stall = 1'b1;
      repeat (ns) begin
        PCSrc = $urandom_range(0, 1) == 1; PCTarget = $urandom;
        cyc;
        chk("rnd_stall_pc", pc, mpc);
        chk("rnd_stall_cnt", instret, mcnt);
        chk_fields("rnd_stall", data);
      end
      stall = 1'b0;
      src = $urandom_range(0, 1) == 1;
      mis = $urandom_range(0, 7) == 0;
      tgt = $urandom;
      tgt[1:0] = mis ? 2'($urandom_range(1, 3)) : 2'b00;
      PCSrc = src; PCTarget = tgt;
      cyc;
      PCSrc = 1'b0;
      mcnt = mcnt + 32'd1;
      chk("rnd_ret_cnt", instret, mcnt);
      chk("rnd_ret_valid", {31'b0, valid}, 32'h0);
      if (src && mis) begin
        chk("rnd_fault", {31'b0, fault}, 32'h1);
        chk("rnd_fault_pc", pc, mpc);
        repeat (3) begin
          imem_rvalid = $urandom_range(0, 1) == 1;
          cyc;
          chk("rnd_fault_quiet", {30'b0, req, fault}, 32'h1);
        end
        imem_rvalid = 1'b0; reset = 1'b1;
        cyc;
        reset = 1'b0;
        cyc;
        mpc = 32'h0; mcnt = 32'h0;
      end else begin
        chk("rnd_nofault", {31'b0, fault}, 32'h0);
        mpc = src ? tgt : mpc + 32'd4;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
